// File: rtl/pci_tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pci_tl_pkg
// Description : Shared transaction-layer types and defaults (arbiter state,
//               word width, destination-select bit).
// Revision    : 1.0 - initial release
// ============================================================================
package pci_tl_pkg;

    // Word width shared by the class demux, VC FIFOs and destination FIFOs
    localparam int c_data_width = 6;
    // Bit of each word that selects D0 (0) or D1 (1)
    localparam int c_dest_bit   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } arb_state_t;

endpackage : pci_tl_pkg
`default_nettype wire

// File: rtl/vc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vc_arbiter_if
// Description : VC FIFO read side and destination FIFO write side of the
//               VC arbiter. master = arbiter, slave = FIFO environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface vc_arbiter_if
    import pci_tl_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width
);
    logic                  empty_vc0;
    logic                  empty_vc1;
    logic [DATA_WIDTH-1:0] data_vc0;
    logic [DATA_WIDTH-1:0] data_vc1;
    logic                  pause_d0;
    logic                  pause_d1;
    logic                  pop_vc0;
    logic                  pop_vc1;
    logic                  push_d0;
    logic                  push_d1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  idle_out;

    modport master (
        input  empty_vc0, empty_vc1, data_vc0, data_vc1, pause_d0, pause_d1,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out, idle_out
    );

    modport slave (
        output empty_vc0, empty_vc1, data_vc0, data_vc1, pause_d0, pause_d1,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out, idle_out
    );

endinterface : vc_arbiter_if
`default_nettype wire

// File: rtl/vc_burst_limiter.sv
`default_nettype none
// ============================================================================
// Module      : vc_burst_limiter
// Description : VC0-priority grant logic with a bounded VC0 burst so that a
//               non-empty VC1 is served after MAX_VC0_BURST VC0 grants.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_burst_limiter #(
    parameter int MAX_VC0_BURST = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_empty_vc0,
    input  wire logic i_empty_vc1,
    input  wire logic i_pause_any,
    output logic      o_grant_vc0,
    output logic      o_grant_vc1
);

    localparam int             CNT_W = $clog2(MAX_VC0_BURST + 1);
    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_VC0_BURST);

    logic [CNT_W-1:0] r_burst_cnt;
    logic             w_grant_vc0;
    logic             w_grant_vc1;

    // Grant: VC1 when VC0 is empty or its burst is used up, else VC0.
    // Reset gating keeps both pops low while reset is held.
    always_comb begin
        w_grant_vc1 = 1'b0;
        w_grant_vc0 = 1'b0;
        if (!reset && !i_pause_any) begin
            w_grant_vc1 = !i_empty_vc1 && (i_empty_vc0 || (r_burst_cnt == c_MAX));
            w_grant_vc0 = !w_grant_vc1 && !i_empty_vc0;
        end
    end

    // Burst counter: counts VC0 grants only while VC1 is waiting.
    // Clearing on an empty VC1 wins over the pause hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (i_empty_vc1 || w_grant_vc1) begin
            r_burst_cnt <= '0;
        end else if (w_grant_vc0) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    assign o_grant_vc0 = w_grant_vc0;
    assign o_grant_vc1 = w_grant_vc1;

endmodule : vc_burst_limiter
`default_nettype wire

// File: rtl/vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vc_arbiter
// Description : Drains VC0/VC1 FIFOs into D0/D1 destination FIFOs, one word
//               per cycle, routed by the destination bit; pauses all pops
//               while either destination is almost full.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_arbiter
    import pci_tl_pkg::*;
#(
    parameter int DATA_WIDTH    = c_data_width,
    parameter int DEST_BIT      = c_dest_bit,
    parameter int MAX_VC0_BURST = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    vc_arbiter_if.master bus
);

    logic                  w_pause_any;
    logic                  w_any_pending;
    logic                  w_grant_vc0;
    logic                  w_grant_vc1;
    logic [DATA_WIDTH-1:0] w_data;

    logic                  r_valid_q;
    logic                  r_sel_q;
    arb_state_t            r_state;
    logic                  r_idle;

    // Destination is unknown before the pop, so either pause blocks both VCs
    assign w_pause_any   = bus.pause_d0 | bus.pause_d1;
    assign w_any_pending = !bus.empty_vc0 || !bus.empty_vc1;

    vc_burst_limiter #(
        .MAX_VC0_BURST (MAX_VC0_BURST)
    ) u_lim (
        .clk         (clk),
        .reset       (reset),
        .i_empty_vc0 (bus.empty_vc0),
        .i_empty_vc1 (bus.empty_vc1),
        .i_pause_any (w_pause_any),
        .o_grant_vc0 (w_grant_vc0),
        .o_grant_vc1 (w_grant_vc1)
    );

    assign bus.pop_vc0 = w_grant_vc0;
    assign bus.pop_vc1 = w_grant_vc1;

    // Track which VC was popped; its read data arrives next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_sel_q   <= 1'b0;
        end else begin
            r_valid_q <= w_grant_vc0 | w_grant_vc1;
            r_sel_q   <= w_grant_vc1;
        end
    end

    // Select the returning read data; zero when nothing is in flight
    always_comb begin
        w_data = '0;
        if (r_valid_q) begin
            w_data = r_sel_q ? bus.data_vc1 : bus.data_vc0;
        end
    end

    assign bus.data_out = w_data;
    assign bus.push_d0  = r_valid_q & ~w_data[DEST_BIT];
    assign bus.push_d1  = r_valid_q &  w_data[DEST_BIT];
    assign bus.idle_out = r_idle;

    // Activity FSM; idle flag is registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_pending) begin
                        r_state <= w_pause_any ? STALL : ACTIVE;
                        r_idle  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (!w_any_pending) begin
                        r_state <= IDLE;
                        r_idle  <= 1'b1;
                    end else if (w_pause_any) begin
                        r_state <= STALL;
                    end
                end
                STALL: begin
                    if (!w_any_pending) begin
                        r_state <= IDLE;
                        r_idle  <= 1'b1;
                    end else if (!w_pause_any) begin
                        r_state <= ACTIVE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule : vc_arbiter
`default_nettype wire

// File: doc/vc_arbiter.md
# vc_arbiter

Transaction-layer arbiter that drains the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1). It grants one VC pop per cycle, with VC0 priority and a bounded-burst rule so VC1 cannot starve. It routes each popped word to D0 or D1 by its destination bit and halts all pops while either destination FIFO signals pause. It sits downstream of the main-FIFO pop logic and the class demux.

## Interface
Parameters:
- DATA_WIDTH, 6, word width of VC and destination FIFOs
- DEST_BIT, 5, bit index selecting destination: 0 → D0, 1 → D1
- MAX_VC0_BURST, 4, maximum consecutive VC0 grants allowed while VC1 is non-empty (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- empty_vc0  in  1  VC0 FIFO empty
- empty_vc1  in  1  VC1 FIFO empty
- data_vc0  in  DATA_WIDTH  VC0 read data, valid the cycle after pop_vc0
- data_vc1  in  DATA_WIDTH  VC1 read data, valid the cycle after pop_vc1
- pause_d0  in  1  D0 almost-full
- pause_d1  in  1  D1 almost-full
- pop_vc0  out  1  VC0 read enable (combinational)
- pop_vc1  out  1  VC1 read enable (combinational)
- push_d0  out  1  D0 write enable
- push_d1  out  1  D1 write enable
- data_out  out  DATA_WIDTH  write data to D0/D1
- idle_out  out  1  high in IDLE state

## Operation
- pause_any = pause_d0 | pause_d1. The destination is unknown before a pop, so either pause blocks all pops.
- Grant rule, evaluated only when !pause_any and !reset:
  - Grant VC1 if !empty_vc1 and (empty_vc0 or burst_cnt == MAX_VC0_BURST).
  - Otherwise grant VC0 if !empty_vc0.
  - Otherwise grant nothing.
- Exactly one grant per cycle at most: pop_vc0 and pop_vc1 are never both high.
- burst_cnt, width clog2(MAX_VC0_BURST+1):
  - Increments on a VC0 grant while empty_vc1 = 0.
  - Clears on a VC1 grant, or on any cycle with empty_vc1 = 1.
  - Holds during pause.
- Pipeline registers: valid_q <= (pop_vc0 | pop_vc1); sel_q <= pop_vc1.
- data_out = valid_q ? (sel_q ? data_vc1 : data_vc0) : 0.
- push_d0 = valid_q & !data_out[DEST_BIT]; push_d1 = valid_q & data_out[DEST_BIT].
- An in-flight word is always pushed, even if pause rises. Destination pause thresholds must therefore leave ≥1 free entry.
- FSM states and transitions (registered):
  - IDLE: both VC FIFOs empty and valid_q = 0.
    - To ACTIVE when either VC FIFO is non-empty and !pause_any.
    - To STALL when either is non-empty and pause_any.
  - ACTIVE: a grant was issued this cycle.
    - To STALL when pause_any and data pending.
    - To IDLE when both empty and no grant.
  - STALL: data pending, pause_any high.
    - To ACTIVE when pause drops.
    - To IDLE when both FIFOs empty.
- Reset, asynchronous, applies at any time:
  - Outputs: pop_* = 0, push_* = 0, data_out = 0, idle_out = 1.
  - State: valid_q = 0, sel_q = 0, burst_cnt = 0, state = IDLE.
  - A word popped in the cycle before reset is discarded.

## Timing
- Pop in cycle N → push_dX with data_out valid in cycle N+1. Latency is 1 cycle.
- Throughput is one word per cycle, back-to-back, with no bubbles between VCs.
- Pause sampled high in cycle N: no pop in N. A pop issued in N-1 still pushes in N.
- Pause falling in cycle N: a pop may issue in N.
- Empty flags are sampled the same cycle. No pop is issued to an empty FIFO.
- idle_out is registered and follows the state with one-cycle delay relative to the inputs.
- Simultaneous VC0/VC1 non-empty with burst_cnt < MAX: VC0 wins.

## Structure
- Shared package pci_tl_pkg holds:
  - Arbiter state enum (IDLE, ACTIVE, STALL).
  - Default DATA_WIDTH and DEST_BIT constants, shared with the class demux and destination FIFOs.
- Sub-module vc_burst_limiter: burst_cnt and the combinational grant logic (inputs empty_vc0, empty_vc1, pause_any; outputs grant_vc0, grant_vc1).
- Top level holds the pipeline registers, the routing logic and the FSM.

## Test plan
- Only VC0 holds 3 words 0x05, 0x25, 0x07; no pause → pops in cycles 1–3.
  - D0 receives 0x05, 0x07; D1 receives 0x25, each one cycle after its pop.
  - idle_out returns to 1 after the last push.
- Both VCs continuously non-empty, MAX_VC0_BURST = 4 → grant sequence VC0×4, VC1×1, repeating. pop_vc0 and pop_vc1 are never both high.
- pause_d1 rises in the cycle after a pop → that word is still pushed. No further pops until pause drops. FSM shows STALL, then ACTIVE within 1 cycle of release.
- VC1 empties mid-burst after 2 VC0 grants → burst_cnt clears to 0. VC1 later refills → 4 more VC0 grants precede the VC1 grant.
- reset asserted asynchronously mid-stream, between clock edges → all outputs 0, with idle_out = 1, immediately. No push for the in-flight word. Normal operation resumes on the first cycle after deassertion.
